// File: rtl/bin_2_gray.sv
// Binary-to-Gray converter with a capture register, Gray decode of the
// captured value and a flag for single-bit Gray steps between captures.
module bin_2_gray #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] g_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] b_dec,
    output logic             valid,
    output logic             step1
);

    logic             have_prev;
    logic [WIDTH-1:0] g_diff;

    assign g      = b ^ (b >> 1);
    assign g_diff = g ^ g_q;

    // Each decoded bit is the XOR of g_q from that bit up to the MSB.
    always_comb begin
        b_dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b_dec[i] = ^(g_q >> i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q       <= '0;
            b_q       <= '0;
            valid     <= 1'b0;
            step1     <= 1'b0;
            have_prev <= 1'b0;
        end else if (en) begin
            g_q       <= g;
            b_q       <= b;
            valid     <= 1'b1;
            have_prev <= 1'b1;
            step1     <= have_prev & $onehot(g_diff);
        end else begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin_2_gray.sv
// Self-checking bench for bin_2_gray (WIDTH=4): combinational sweeps with no
// clock, then scoreboarded captures, holds and asynchronous resets.
module tb_bin_2_gray;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst_n;
    logic [3:0] b;
    logic       en;
    logic [3:0] g, g_q, b_q, b_dec;
    logic       valid, step1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] gq;
        logic [3:0] bq;
        logic       v;
        logic       s;
    } exp_t;

    exp_t exp_q[$];

    logic [3:0] m_gq, m_bq;
    logic       m_have, m_step;
    logic [3:0] gray_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    bin_2_gray #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .b     (b),
        .en    (en),
        .g     (g),
        .g_q   (g_q),
        .b_q   (b_q),
        .b_dec (b_dec),
        .valid (valid),
        .step1 (step1)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_diffs(input logic [3:0] x, input logic [3:0] y);
        int n = 0;
        for (int i = 0; i < 4; i++) if (x[i] != y[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_gq   = '0;
        m_bq   = '0;
        m_have = 1'b0;
        m_step = 1'b0;
    endtask

    // One cycle: drive at the falling edge, predict, compare after the rising edge.
    task automatic drive(input logic [3:0] val, input logic e);
        exp_t x, o;
        @(negedge clk);
        b  = val;
        en = e;
        #1 check_val("g_live", g, gray_tbl[val]);
        if (e) begin
            x.s    = m_have ? (bit_diffs(gray_tbl[val], m_gq) == 1) : 1'b0;
            m_gq   = gray_tbl[val];
            m_bq   = val;
            m_have = 1'b1;
            x.v    = 1'b1;
        end else begin
            x.s = m_step;
            x.v = 1'b0;
        end
        m_step = x.s;
        x.gq   = m_gq;
        x.bq   = m_bq;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            o = exp_q.pop_front();
            check_val("g_q", g_q, o.gq);
            check_val("b_q", b_q, o.bq);
            check_val("b_dec", b_dec, o.bq);
            check_val("valid", valid, o.v);
            check_val("step1", step1, o.s);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_g_q"}, g_q, 0);
        check_val({tag, "_b_q"}, b_q, 0);
        check_val({tag, "_b_dec"}, b_dec, 0);
        check_val({tag, "_valid"}, valid, 0);
        check_val({tag, "_step1"}, step1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        en    = 1'b0;
        b     = 4'd0;
        model_reset();
        #1 check_reset_state("rst0");

        for (int i = 0; i < 16; i++) begin
            b = 4'(i);
            #1 check_val("sweep_g", g, gray_tbl[i]);
        end

        for (int i = 0; i < 10; i++) begin
            r = 4'($urandom_range(0, 15));
            b = r;
            #10 check_val("rand_g", g, gray_tbl[r]);
        end
        check_reset_state("rst_noclk");

        rst_n   = 1'b1;
        clk_run = 1'b1;

        drive(4'b0101, 1'b1);
        check_val("first_g_q", g_q, 4'b0111);
        check_val("first_step1", step1, 0);

        // Count 0..15 then wrap to 0, then repeat 0.
        for (int i = 0; i < 16; i++) drive(4'(i), 1'b1);
        drive(4'd0, 1'b1);
        check_val("wrap_step1", step1, 1);
        drive(4'd0, 1'b0);
        drive(4'd0, 1'b1);
        check_val("repeat_step1", step1, 0);

        drive(4'b1111, 1'b1);
        drive(4'b0011, 1'b0);
        drive(4'b1010, 1'b0);
        drive(4'b0110, 1'b0);
        check_val("hold_g_q", g_q, 4'b1000);
        check_val("hold_valid", valid, 0);

        drive(4'd9, 1'b1);
        drive(4'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        b     = 4'b0110;
        #1 check_reset_state("rst_async");
        check_val("rst_g_live", g, 4'b0101);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd3, 1'b1);
        check_val("post_rst_step1", step1, 0);
        drive(4'd2, 1'b1);
        drive(4'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
